// File: rtl/rca8_seq_ctrl_if.sv
// Request/response bundle between the execute stage and the byte-serial
// add/subtract sequencer. The controller side is the slave modport.
interface rca8_seq_ctrl_if #(
    parameter int NBYTES = 4
);
    localparam int W = 8 * NBYTES;

    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic [W-1:0] result;
    logic         res_cout;
    logic         res_ovf;
    logic         res_zero;
    logic         res_valid;
    logic         res_ready;
    logic         busy;

    modport master (
        output start_valid, op_a, op_b, sub, res_ready,
        input  start_ready, result, res_cout, res_ovf, res_zero, res_valid, busy
    );

    modport slave (
        input  start_valid, op_a, op_b, sub, res_ready,
        output start_ready, result, res_cout, res_ovf, res_zero, res_valid, busy
    );
endinterface

// File: rtl/rca8_seq_ctrl.sv
// Byte-serial multi-byte add/subtract controller. One external 8-bit adder
// is reused for NBYTES cycles, least-significant byte first; subtraction is
// done as A + ~B + 1 with the +1 entering as the initial carry.
module rca8_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    rca8_seq_ctrl_if.slave    bus,
    output logic [7:0]        add_a,
    output logic [7:0]        add_b,
    output logic              add_cin,
    input  logic [7:0]        add_sum,
    input  logic              add_cout
);
    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    opa_q, opb_q;
    logic [W-1:0]    result_q, result_d;
    logic            carry_q;
    logic [IDXW-1:0] idx_q;
    logic            cout_q, ovf_q, zero_q;
    logic            accept, last;

    // Signed overflow: operands agree in sign but the sum does not.
    // b_msb is the already-inverted operand when subtracting.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    // Next-state decode, adder drive and merge of the current sum byte.
    always_comb begin
        state_d  = state_q;
        add_a    = '0;
        add_b    = '0;
        add_cin  = 1'b0;
        accept   = 1'b0;
        last     = 1'b0;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                add_a                = opa_q[8*idx_q +: 8];
                add_b                = opb_q[8*idx_q +: 8];
                add_cin              = carry_q;
                result_d[8*idx_q +: 8] = add_sum;
                if (idx_q == LAST) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Byte index, result assembly and flags captured on the final byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else if (accept) begin
            idx_q    <= '0;
            result_q <= '0;
        end else if (state_q == RUN) begin
            idx_q    <= idx_q + IDXW'(1);
            result_q <= result_d;
            if (last) begin
                cout_q <= add_cout;
                ovf_q  <= signed_ovf(opa_q[W-1], opb_q[W-1], add_sum[7]);
                zero_q <= (result_d == '0);
            end
        end
    end

    // Operand and inter-byte carry registers; only meaningful while RUN.
    always_ff @(posedge clk) begin
        if (accept) begin
            opa_q   <= bus.op_a;
            opb_q   <= bus.sub ? ~bus.op_b : bus.op_b;
            carry_q <= bus.sub;
        end else if (state_q == RUN) begin
            carry_q <= add_cout;
        end
    end

    assign bus.start_ready = rst_n && (state_q == IDLE);
    assign bus.res_valid   = (state_q == DONE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.result      = result_q;
    assign bus.res_cout    = cout_q;
    assign bus.res_ovf     = ovf_q;
    assign bus.res_zero    = zero_q;
endmodule

// File: doc/rca8_seq_ctrl.md
Name: rca8_seq_ctrl

Overview:
- Byte-serial sequencer that reuses one 8-bit ripple-carry adder to perform multi-byte add/subtract on 8*NBYTES-bit operands, least-significant byte first.
- Sits between the CPU execute stage, through a valid/ready request/response handshake, and one external 8-bit adder instance, through the add_* ports.
- Owns the byte index, the inter-byte carry register, operand inversion for subtract, result assembly and flags.

Parameters:
- NBYTES, 4, operand/result width in bytes (legal range ≥1); operand width W = 8*NBYTES.

Ports:
- clk  in  1  system clock, all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- start_valid  in  1  request valid
- start_ready  out  1  controller can accept a request
- op_a  in  W  operand A, sampled on accept
- op_b  in  W  operand B, sampled on accept
- sub  in  1  0 = A+B, 1 = A-B; sampled on accept
- add_a  out  8  byte of A to adder
- add_b  out  8  byte of B, or ~B when subtracting, to adder
- add_cin  out  1  carry into adder
- add_sum  in  8  adder sum, combinational from add_*
- add_cout  in  1  adder carry out
- result  out  W  assembled result
- res_cout  out  1  final carry; for subtract, 1 = no borrow
- res_ovf  out  1  signed two's-complement overflow
- res_zero  out  1  result == 0
- res_valid  out  1  response valid
- res_ready  in  1  consumer accepts response
- busy  out  1  high in RUN or DONE

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE. result, res_cout, res_ovf, res_zero, res_valid, busy, add_a, add_b, add_cin all 0. start_ready=1 once reset is released.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On a clock edge with start_valid=1, latch op_a into reg A, latch (sub ? ~op_b : op_b) into reg B, set carry reg=sub, idx=0, clear result reg, then go to RUN.
- RUN:
  - add_a=A[8*idx+:8], add_b=B[8*idx+:8], add_cin=carry reg.
  - Each edge: result[8*idx+:8] <= add_sum, carry <= add_cout, idx <= idx+1.
  - When idx==NBYTES-1, also go to DONE.
  - RUN lasts exactly NBYTES cycles.
- DONE:
  - res_valid=1; result and flags held stable.
  - Leave to IDLE on the edge where res_ready=1.
- Flags, registered on the final RUN edge:
  - res_cout = add_cout of the last byte.
  - res_ovf = (A[W-1]==B[W-1]) && (add_sum[7]!=A[W-1]), where B is the possibly-inverted operand.
  - res_zero = 1 iff the full W-bit result is 0.
- Latency: request accepted at edge N → res_valid=1 after edge N+NBYTES. Minimum issue interval is NBYTES+2 cycles, because start_ready=0 in RUN and DONE (no same-cycle restart from DONE).
- add_a, add_b and add_cin are 0 in IDLE and DONE.
- NBYTES=1: single RUN cycle.
- start_valid while busy: ignored, with no side effects.
- Response outputs hold until accepted, regardless of how long res_ready stays low.
- Reset mid-RUN or mid-DONE: operation aborted, no response produced, all outputs return to their reset values.
- Arithmetic is modulo 2^W; no saturation.

Test Plan (NBYTES=4, external adder connected):
- Reset: assert rst_n=0 mid-cycle → all outputs 0 immediately, without waiting for a clock edge. After release: start_ready=1, busy=0.
- Byte carry: add 0x000000FF + 0x00000001 → result 0x00000100, res_cout=0, res_ovf=0, res_zero=0; res_valid rises exactly 4 edges after accept.
- Full wrap: add 0xFFFFFFFF + 0x00000001 → result 0x00000000, res_cout=1, res_zero=1, res_ovf=0. Add 0x7FFFFFFF + 0x00000001 → 0x80000000, res_ovf=1.
- Subtract: 0x80000000 - 0x00000001 → 0x7FFFFFFF, res_ovf=1, res_cout=1. 0x00000005 - 0x00000007 → 0xFFFFFFFE, res_cout=0, res_ovf=0.
- Backpressure: hold res_ready=0 for 10 cycles in DONE → res_valid, result and flags stable throughout; start_valid=1 with new operands is not accepted. Then res_ready=1 → IDLE; the pending start is accepted on the next edge.
- Abort: pulse rst_n low after 2 RUN cycles → no res_valid ever produced. A following request 0x12345678 + 0x11111111 → 0x23456789.
